// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared ALU definitions: shift op encoding, FLAGS bit positions, FSM states
package seq_shifter_pkg;

    typedef enum logic [2:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_SAR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4,
        OP_RCL = 3'd5,
        OP_RCR = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CF_BIT = 0;
    localparam int PF_BIT = 2;
    localparam int AF_BIT = 4;
    localparam int ZF_BIT = 6;
    localparam int SF_BIT = 7;
    localparam int OF_BIT = 11;

    function automatic logic even_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bundle between a shift requester and seq_shifter
interface seq_shifter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic             is_8_bit;
    logic [WIDTH-1:0] a;
    logic [7:0]       count;
    logic [15:0]      flags_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [15:0]      flags_out;

    modport master (
        output start, op, is_8_bit, a, count, flags_in,
        input  busy, done, out, flags_out
    );

    modport slave (
        input  start, op, is_8_bit, a, count, flags_in,
        output busy, done, out, flags_out
    );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// shift_step: applies up to STEP single-bit shift/rotate steps in one cycle and derives OF from the last one
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  op_e              op,
    input  logic             is_8_bit,
    input  logic [WIDTH-1:0] val,
    input  logic             cf,
    input  logic [2:0]       k,
    output logic [WIDTH-1:0] val_n,
    output logic             cf_n,
    output logic             of_n
);
    localparam int MW = $clog2(WIDTH);

    logic [MW-1:0]    m;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] pv;
    logic             c;

    function automatic logic [WIDTH:0] one_bit(
        input op_e              o,
        input logic [WIDTH-1:0] x,
        input logic             ci,
        input logic [MW-1:0]    mi,
        input logic [WIDTH-1:0] mk
    );
        logic hi;
        logic lo;
        hi = x[mi];
        lo = x[0];
        case (o)
            OP_SHL:  one_bit = {hi, (x << 1) & mk};
            OP_SHR:  one_bit = {lo, x >> 1};
            OP_SAR:  one_bit = {lo, (x >> 1) | (WIDTH'(hi) << mi)};
            OP_ROL:  one_bit = {hi, ((x << 1) | WIDTH'(hi)) & mk};
            OP_ROR:  one_bit = {lo, (x >> 1) | (WIDTH'(lo) << mi)};
            OP_RCL:  one_bit = {hi, ((x << 1) | WIDTH'(ci)) & mk};
            OP_RCR:  one_bit = {lo, (x >> 1) | (WIDTH'(ci) << mi)};
            default: one_bit = {ci, x};
        endcase
    endfunction

    assign m    = is_8_bit ? MW'(7) : MW'(WIDTH - 1);
    assign mask = is_8_bit ? WIDTH'(8'hFF) : {WIDTH{1'b1}};

    // chain k single-bit steps; pv keeps the operand seen by the final step for the SHR overflow rule
    always_comb begin
        v  = val;
        c  = cf;
        pv = val;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k)) begin
                pv     = v;
                {c, v} = one_bit(op, v, c, m, mask);
            end
        end
        val_n = v;
        cf_n  = c;
        of_n  = (op == OP_SHR) ? pv[m] :
                (op == OP_SAR) ? 1'b0 :
                (op == OP_ROR || op == OP_RCR) ? (v[m] ^ v[m - 1'b1]) :
                (v[m] ^ c);
    end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle x86 shift/rotate unit; define SHIFT_COUNT_MASK_EN to mask the count to 5 bits (80186 behaviour)
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    seq_shifter_if.slave bus
);
    state_e           state;
    state_e           state_n;
    logic [7:0]       n;
    logic [7:0]       rem;
    logic [2:0]       k;
    logic             last;
    logic             accept;
    logic             shift_op;
    op_e              op_q;
    logic             w8_q;
    logic             cf_q;
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] val_n;
    logic             cf_n;
    logic             of_n;
    logic [15:0]      fin_q;
    logic [15:0]      fout_q;
    logic [15:0]      flags_done;

`ifdef SHIFT_COUNT_MASK_EN
    assign n = (bus.op == 3'd7) ? 8'd0 : {3'b000, bus.count[4:0]};
`else
    assign n = (bus.op == 3'd7) ? 8'd0 : bus.count;
`endif

    assign a_m      = bus.is_8_bit ? WIDTH'(bus.a[7:0]) : bus.a;
    assign accept   = (state == IDLE) && bus.start;
    assign k        = (rem >= 8'(STEP)) ? 3'(STEP) : rem[2:0];
    assign last     = rem <= 8'(STEP);
    assign shift_op = (op_q == OP_SHL) || (op_q == OP_SHR) || (op_q == OP_SAR);
    assign bus.out       = res_q;
    assign bus.flags_out = fout_q;

    shift_step #(
        .WIDTH(WIDTH),
        .STEP (STEP)
    ) u_step (
        .op      (op_q),
        .is_8_bit(w8_q),
        .val     (val_q),
        .cf      (cf_q),
        .k       (k),
        .val_n   (val_n),
        .cf_n    (cf_n),
        .of_n    (of_n)
    );

    // FLAGS image produced by the final RUN cycle; rotates touch only CF and OF
    always_comb begin
        flags_done         = fin_q;
        flags_done[CF_BIT] = cf_n;
        flags_done[OF_BIT] = of_n;
        flags_done[SF_BIT] = shift_op ? (w8_q ? val_n[7] : val_n[WIDTH-1]) : fin_q[SF_BIT];
        flags_done[ZF_BIT] = shift_op ? (val_n == '0) : fin_q[ZF_BIT];
        flags_done[PF_BIT] = shift_op ? even_parity(val_n[7:0]) : fin_q[PF_BIT];
    end

    // next state and status outputs
    always_comb begin
        state_n  = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE:    state_n = accept ? ((n == 8'd0) ? DONE : RUN) : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            default: state_n = IDLE;
        endcase
        bus.busy = (state == RUN) || (state == DONE);
        bus.done = (state == DONE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // operand capture, per-cycle stepping, and result hold until the next accepted start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q   <= OP_SHL;
            w8_q   <= 1'b0;
            cf_q   <= 1'b0;
            rem    <= 8'd0;
            val_q  <= '0;
            fin_q  <= 16'd0;
            res_q  <= '0;
            fout_q <= 16'd0;
        end else if (accept) begin
            op_q  <= op_e'(bus.op);
            w8_q  <= bus.is_8_bit;
            cf_q  <= bus.flags_in[CF_BIT];
            rem   <= n;
            val_q <= a_m;
            fin_q <= bus.flags_in;
            if (n == 8'd0) begin
                res_q  <= a_m;
                fout_q <= bus.flags_in;
            end
        end else if (state == RUN) begin
            val_q <= val_n;
            cf_q  <= cf_n;
            rem   <= rem - 8'(k);
            if (last) begin
                res_q  <= val_n;
                fout_q <= flags_done;
            end
        end
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_seq_shifter;
    typedef struct {
        logic [15:0] out;
        logic [15:0] flags;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q[$];
    exp_t e;

    seq_shifter_if #(.WIDTH(16)) bus ();

    seq_shifter #(
        .WIDTH(16),
        .STEP (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("out", 32'(bus.out), 32'(e.out));
                chk("flags_out", 32'(bus.flags_out), 32'(e.flags));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic is8, input logic [15:0] a,
                         input logic [7:0] cnt, input logic [15:0] fin, input logic [15:0] eo,
                         input logic [15:0] ef, input int lat, input bit push);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.is_8_bit = is8;
        bus.a        = a;
        bus.count    = cnt;
        bus.flags_in = fin;
        if (push) q.push_back('{eo, ef, cyc + lat});
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic is8, input logic [15:0] a,
                          input logic [7:0] cnt, input logic [15:0] fin, input logic [15:0] eo,
                          input logic [15:0] ef, input int lat);
        issue(op, is8, a, cnt, fin, eo, ef, lat, 1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        chk("hold_out", 32'(bus.out), 32'(eo));
        chk("hold_flags", 32'(bus.flags_out), 32'(ef));
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 3'd0;
        bus.is_8_bit = 1'b0;
        bus.a        = 16'h0;
        bus.count    = 8'd0;
        bus.flags_in = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_out", 32'(bus.out), 32'd0);
        chk("reset_flags", 32'(bus.flags_out), 32'd0);
        reset_n = 1'b1;

        //      op    is8   a         cnt     flags_in  out       flags     lat
        run_op(3'd0, 1'b0, 16'h8001, 8'd1,   16'h0000, 16'h0002, 16'h0801, 2);
        run_op(3'd2, 1'b1, 16'h1280, 8'd3,   16'h0000, 16'h00F0, 16'h0084, 3);
        run_op(3'd6, 1'b0, 16'h0001, 8'd1,   16'h0001, 16'h8000, 16'h0801, 2);
`ifdef SHIFT_COUNT_MASK_EN
        run_op(3'd1, 1'b0, 16'h0004, 8'h21,  16'h0000, 16'h0002, 16'h0000, 2);
`else
        run_op(3'd1, 1'b0, 16'h0004, 8'h21,  16'h0000, 16'h0000, 16'h0044, 18);
`endif
        run_op(3'd3, 1'b0, 16'h1234, 8'd0,   16'h08D5, 16'h1234, 16'h08D5, 1);
        run_op(3'd7, 1'b0, 16'hABCD, 8'd5,   16'h0003, 16'hABCD, 16'h0003, 1);
        run_op(3'd3, 1'b0, 16'h8001, 8'd4,   16'h00D5, 16'h0018, 16'h00D4, 3);
        run_op(3'd4, 1'b1, 16'h0001, 8'd1,   16'h0000, 16'h0080, 16'h0801, 2);
        run_op(3'd5, 1'b1, 16'h0080, 8'd9,   16'h0000, 16'h0080, 16'h0800, 6);
        run_op(3'd0, 1'b0, 16'hFFFF, 8'd17,  16'h0000, 16'h0000, 16'h0044, 10);
        run_op(3'd2, 1'b0, 16'h8000, 8'd20,  16'h0000, 16'hFFFF, 16'h0085, 11);
        run_op(3'd1, 1'b0, 16'h8000, 8'd1,   16'h0000, 16'h4000, 16'h0804, 2);
        run_op(3'd0, 1'b1, 16'h00C0, 8'd1,   16'h0000, 16'h0080, 16'h0081, 2);

        // a second start while running must be dropped entirely
        issue(3'd0, 1'b0, 16'h0001, 8'd6, 16'h0000, 16'h0040, 16'h0000, 4, 1'b1);
        bus.op       = 3'd1;
        bus.a        = 16'hFFFF;
        bus.count    = 8'd1;
        bus.flags_in = 16'h08FF;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        chk("ignored_start_out", 32'(bus.out), 32'h0040);
        chk("ignored_start_flags", 32'(bus.flags_out), 32'h0000);
        chk("ignored_start_busy", 32'(bus.busy), 32'd0);

        // reset in the middle of a long operation aborts it without a done pulse
        issue(3'd1, 1'b0, 16'hFFFF, 8'd10, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_out", 32'(bus.out), 32'd0);
        chk("abort_flags", 32'(bus.flags_out), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_quiet_busy", 32'(bus.busy), 32'd0);

        run_op(3'd1, 1'b0, 16'h8000, 8'd1,   16'h0000, 16'h4000, 16'h0804, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
